// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared keypad encoding used by both the keypad scanner and the
//            keypad emulator: key codes, column/row line patterns and the
//            emulator state type.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  // Key codes as emitted by the scanner.
  localparam logic [2:0] KP_NONE   = 3'b000;
  localparam logic [2:0] KP_100    = 3'b001;
  localparam logic [2:0] KP_500    = 3'b010;
  localparam logic [2:0] KP_CANDY  = 3'b101;
  localparam logic [2:0] KP_CHANGE = 3'b110;
  localparam logic [2:0] KP_RESET  = 3'b111;

  // One-hot column strobes.
  localparam logic [2:0] COL_NONE = 3'b000;
  localparam logic [2:0] COL_1    = 3'b001;
  localparam logic [2:0] COL_2    = 3'b010;
  localparam logic [2:0] COL_3    = 3'b100;

  // Active-high row lines.
  localparam logic [3:0] ROW_NONE = 4'b0000;
  localparam logic [3:0] ROW_1    = 4'b0001;
  localparam logic [3:0] ROW_2    = 4'b0010;
  localparam logic [3:0] ROW_3    = 4'b0100;
  localparam logic [3:0] ROW_4    = 4'b1000;

  // Emulator press/release sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_RELEASE    = 3'd4
  } kp_state_t;

endpackage
`default_nettype wire

// File: rtl/keypad_emulator_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_emulator_if
// Purpose  : Scan lines plus key-request handshake between a key-entry
//            master (script / testbench) and the keypad emulator.
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_emulator_if;
  logic [2:0] col;
  logic [3:0] row;
  logic       req_valid;
  logic [2:0] req_code;
  logic       req_ready;
  logic       busy;
  logic       done;
  logic       err;

  // Side that strobes columns and issues key requests.
  modport master (
    output col, req_valid, req_code,
    input  row, req_ready, busy, done, err
  );

  // The emulated keypad itself.
  modport slave (
    input  col, req_valid, req_code,
    output row, req_ready, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/keypad_key_lut.sv
`default_nettype none
// ============================================================================
// Module   : keypad_key_lut
// Purpose  : Maps a key code to the switch position it closes, expressed as
//            the (column, row) pair wired together by that key.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_key_lut
  import keypad_pkg::*;
(
  input  logic [2:0] i_code,
  output logic       o_valid,
  output logic [2:0] o_col,
  output logic [3:0] o_row
);

  // Code decode; unpopulated codes report invalid with no lines selected.
  always_comb begin
    o_valid = 1'b0;
    o_col   = COL_NONE;
    o_row   = ROW_NONE;
    case (i_code)
      KP_100:    begin o_valid = 1'b1; o_col = COL_1; o_row = ROW_1; end
      KP_500:    begin o_valid = 1'b1; o_col = COL_2; o_row = ROW_2; end
      KP_CANDY:  begin o_valid = 1'b1; o_col = COL_1; o_row = ROW_4; end
      KP_CHANGE: begin o_valid = 1'b1; o_col = COL_3; o_row = ROW_4; end
      KP_RESET:  begin o_valid = 1'b1; o_col = COL_2; o_row = ROW_4; end
      KP_NONE:   begin end
      default:   begin end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : keypad_emulator
// Purpose  : Behaves as one physical key on a 3x4 scanned keypad. A request
//            closes the selected switch through optional press bounce, a
//            solid hold, optional release bounce and a minimum open time.
//            The row lines are pure combinational wiring from the column
//            strobe, exactly like a real switch matrix.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES    = 1000,
  parameter int BOUNCE_CYCLES  = 16,
  parameter int BOUNCE_PERIOD  = 3,
  parameter int RELEASE_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  keypad_emulator_if.slave  bus
);

  // Phase counters count down from (length-1) to 0; a zero length is run
  // as a single cycle so every phase is visible for at least one clock.
  localparam logic [CNT_W-1:0] c_hold_last    =
    CNT_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_release_last =
    CNT_W'((RELEASE_CYCLES == 0) ? 0 : RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_bounce_last  =
    CNT_W'((BOUNCE_CYCLES == 0) ? 0 : BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_period_last  =
    CNT_W'((BOUNCE_PERIOD < 1) ? 0 : BOUNCE_PERIOD - 1);
  localparam logic [CNT_W-1:0] c_one          = CNT_W'(1);

  kp_state_t        r_state;
  kp_state_t        w_state_n;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] w_phase_n;
  logic [CNT_W-1:0] r_sub;
  logic [CNT_W-1:0] w_sub_n;
  logic             r_contact;
  logic             w_contact_n;
  logic             r_done;
  logic             w_done_n;
  logic             r_err;
  logic             w_err_n;
  logic             w_tgt_load;
  logic [2:0]       r_tgt_col;
  logic [3:0]       r_tgt_row;

  logic             w_lut_valid;
  logic [2:0]       w_lut_col;
  logic [3:0]       w_lut_row;

  keypad_key_lut u_key_lut (
    .i_code  (bus.req_code),
    .o_valid (w_lut_valid),
    .o_col   (w_lut_col),
    .o_row   (w_lut_row)
  );

  // State, counters, contact, target latch and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_phase   <= '0;
      r_sub     <= '0;
      r_contact <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_tgt_col <= COL_NONE;
      r_tgt_row <= ROW_NONE;
    end else begin
      r_state   <= w_state_n;
      r_phase   <= w_phase_n;
      r_sub     <= w_sub_n;
      r_contact <= w_contact_n;
      r_done    <= w_done_n;
      r_err     <= w_err_n;
      if (w_tgt_load) begin
        r_tgt_col <= w_lut_col;
        r_tgt_row <= w_lut_row;
      end
    end
  end

  // Next-state, counter reloads and contact waveform for each phase.
  always_comb begin
    w_state_n   = r_state;
    w_phase_n   = r_phase;
    w_sub_n     = r_sub;
    w_contact_n = r_contact;
    w_done_n    = 1'b0;
    w_err_n     = 1'b0;
    w_tgt_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (w_lut_valid) begin
            w_tgt_load  = 1'b1;
            w_contact_n = 1'b1;
            w_sub_n     = '0;
            if (BOUNCE_CYCLES == 0) begin
              w_state_n = ST_HOLD;
              w_phase_n = c_hold_last;
            end else begin
              w_state_n = ST_BOUNCE_IN;
              w_phase_n = c_bounce_last;
            end
          end else begin
            w_err_n = 1'b1;
          end
        end
      end
      ST_BOUNCE_IN, ST_BOUNCE_OUT: begin
        if (r_phase == '0) begin
          w_sub_n = '0;
          if (r_state == ST_BOUNCE_IN) begin
            w_state_n   = ST_HOLD;
            w_phase_n   = c_hold_last;
            w_contact_n = 1'b1;
          end else begin
            w_state_n   = ST_RELEASE;
            w_phase_n   = c_release_last;
            w_contact_n = 1'b0;
          end
        end else begin
          w_phase_n = r_phase - c_one;
          if (r_sub == c_period_last) begin
            w_sub_n     = '0;
            w_contact_n = ~r_contact;
          end else begin
            w_sub_n = r_sub + c_one;
          end
        end
      end
      ST_HOLD: begin
        if (r_phase == '0) begin
          w_contact_n = 1'b0;
          w_sub_n     = '0;
          if (BOUNCE_CYCLES == 0) begin
            w_state_n = ST_RELEASE;
            w_phase_n = c_release_last;
          end else begin
            w_state_n = ST_BOUNCE_OUT;
            w_phase_n = c_bounce_last;
          end
        end else begin
          w_phase_n = r_phase - c_one;
        end
      end
      ST_RELEASE: begin
        if (r_phase == '0) begin
          w_state_n = ST_IDLE;
          w_done_n  = 1'b1;
        end else begin
          w_phase_n = r_phase - c_one;
        end
      end
      default: begin
        w_state_n   = ST_IDLE;
        w_contact_n = 1'b0;
      end
    endcase
  end

  // Switch-matrix wiring: the closed key shorts its column onto its row.
  always_comb begin
    bus.row = (r_contact && (bus.col == r_tgt_col)) ? r_tgt_row : ROW_NONE;
  end

  // Handshake and status outputs.
  always_comb begin
    bus.req_ready = (r_state == ST_IDLE);
    bus.busy      = (r_state != ST_IDLE);
    bus.done      = r_done;
    bus.err       = r_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_emulator
// Purpose  : Self-checking bench for keypad_emulator. Instance A runs
//            without bounce, instance B with bounce; both are compared every
//            cycle against a timeline model of the key press.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;
  import keypad_pkg::*;

  localparam int A_H = 8, A_B = 0, A_P = 3, A_R = 4;
  localparam int B_H = 8, B_B = 6, B_P = 2, B_R = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  keypad_emulator_if ifa ();
  keypad_emulator_if ifb ();

  keypad_emulator #(.HOLD_CYCLES(A_H), .BOUNCE_CYCLES(A_B), .BOUNCE_PERIOD(A_P),
                    .RELEASE_CYCLES(A_R), .CNT_W(16))
    u_dut_a (.clk(clk), .reset(reset), .bus(ifa));

  keypad_emulator #(.HOLD_CYCLES(B_H), .BOUNCE_CYCLES(B_B), .BOUNCE_PERIOD(B_P),
                    .RELEASE_CYCLES(B_R), .CNT_W(16))
    u_dut_b (.clk(clk), .reset(reset), .bus(ifb));

  always #5 clk = ~clk;

  // Reference model: a press is a timeline indexed by k = cycles since accept.
  logic       m_busy [2] = '{1'b0, 1'b0};
  int         m_k    [2] = '{0, 0};
  logic [2:0] m_code [2] = '{3'b0, 3'b0};
  logic       m_done [2] = '{1'b0, 1'b0};
  logic       m_err  [2] = '{1'b0, 1'b0};

  function automatic int eff(int n); return (n == 0) ? 1 : n; endfunction
  function automatic int par_h(int i); return (i == 0) ? A_H : B_H; endfunction
  function automatic int par_b(int i); return (i == 0) ? A_B : B_B; endfunction
  function automatic int par_p(int i); return (i == 0) ? A_P : B_P; endfunction
  function automatic int par_r(int i); return (i == 0) ? A_R : B_R; endfunction

  function automatic int total(int i);
    return 2 * par_b(i) + eff(par_h(i)) + eff(par_r(i));
  endfunction

  function automatic logic contact_at(int i, int k);
    int b = par_b(i), h = eff(par_h(i)), p = par_p(i);
    if (k <= b)         return ((k - 1) / p) % 2 == 0;
    if (k <= b + h)     return 1'b1;
    if (k <= 2 * b + h) return ((k - b - h - 1) / p) % 2 == 1;
    return 1'b0;
  endfunction

  function automatic logic legal(logic [2:0] c);
    return (c == 3'b001) || (c == 3'b010) || (c == 3'b101) || (c == 3'b110) || (c == 3'b111);
  endfunction

  function automatic logic [2:0] key_col(logic [2:0] c);
    case (c)
      3'b001, 3'b101: return 3'b001;
      3'b010, 3'b111: return 3'b010;
      3'b110:         return 3'b100;
      default:        return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] key_row(logic [2:0] c);
    case (c)
      3'b001:                 return 4'b0001;
      3'b010:                 return 4'b0010;
      3'b101, 3'b110, 3'b111: return 4'b1000;
      default:                return 4'b0000;
    endcase
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_k[i] = 0; m_done[i] = 1'b0; m_err[i] = 1'b0;
    end
  endtask

  task automatic check_inst(int i, logic [2:0] col, logic [3:0] row, logic rdy,
                            logic bsy, logic dn, logic er);
    logic [3:0] exp_row;
    exp_row = (m_busy[i] && contact_at(i, m_k[i]) && col == key_col(m_code[i]))
              ? key_row(m_code[i]) : 4'b0000;
    cmp($sformatf("model_row%0d", i), row, exp_row);
    cmp($sformatf("model_ready%0d", i), rdy, !m_busy[i]);
    cmp($sformatf("model_busy%0d", i), bsy, m_busy[i]);
    cmp($sformatf("model_done%0d", i), dn, m_done[i]);
    cmp($sformatf("model_err%0d", i), er, m_err[i]);
  endtask

  task automatic advance(int i, logic v, logic [2:0] c);
    m_done[i] = 1'b0;
    m_err[i]  = 1'b0;
    if (m_busy[i]) begin
      if (m_k[i] >= total(i)) begin
        m_busy[i] = 1'b0;
        m_done[i] = 1'b1;
      end else begin
        m_k[i] = m_k[i] + 1;
      end
    end else if (v) begin
      if (legal(c)) begin
        m_busy[i] = 1'b1; m_k[i] = 1; m_code[i] = c;
      end else begin
        m_err[i] = 1'b1;
      end
    end
  endtask

  // One clock: check both DUTs mid-cycle, advance the model, return after edge.
  task automatic step();
    @(negedge clk);
    check_inst(0, ifa.col, ifa.row, ifa.req_ready, ifa.busy, ifa.done, ifa.err);
    check_inst(1, ifb.col, ifb.row, ifb.req_ready, ifb.busy, ifb.done, ifb.err);
    if (reset) model_reset();
    else begin
      advance(0, ifa.req_valid, ifa.req_code);
      advance(1, ifb.req_valid, ifb.req_code);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200 && (ifa.busy || ifb.busy); n++) step();
    cmp("idle_timeout", {ifa.busy, ifb.busy}, 2'b00);
  endtask

  function automatic logic [2:0] rand_col();
    int r = $urandom_range(0, 4);
    if (r == 3) return 3'($urandom_range(0, 7));
    if (r == 4) return 3'b000;
    return 3'(1 << r);
  endfunction

  typedef struct {
    logic [2:0] code;
    logic [2:0] col;
    logic [3:0] exp_row;
    logic       exp_err;
  } vec_t;

  vec_t       tbl [12];
  logic [2:0] rot [3];
  logic       exp3 [24];

  // Main stimulus and hand-written corner sequences.
  initial begin
    tbl[0]  = '{3'b001, 3'b001, 4'b0001, 1'b0};
    tbl[1]  = '{3'b001, 3'b010, 4'b0000, 1'b0};
    tbl[2]  = '{3'b010, 3'b010, 4'b0010, 1'b0};
    tbl[3]  = '{3'b010, 3'b100, 4'b0000, 1'b0};
    tbl[4]  = '{3'b101, 3'b001, 4'b1000, 1'b0};
    tbl[5]  = '{3'b110, 3'b100, 4'b1000, 1'b0};
    tbl[6]  = '{3'b110, 3'b110, 4'b0000, 1'b0};
    tbl[7]  = '{3'b111, 3'b010, 4'b1000, 1'b0};
    tbl[8]  = '{3'b111, 3'b000, 4'b0000, 1'b0};
    tbl[9]  = '{3'b000, 3'b001, 4'b0000, 1'b1};
    tbl[10] = '{3'b011, 3'b010, 4'b0000, 1'b1};
    tbl[11] = '{3'b100, 3'b100, 4'b0000, 1'b1};
    rot = '{3'b001, 3'b010, 3'b100};
    exp3 = '{1,1,0,0,1,1, 1,1,1,1,1,1,1,1, 0,0,1,1,0,0, 0,0,0,0};

    ifa.col = 3'b000; ifa.req_valid = 1'b0; ifa.req_code = 3'b000;
    ifb.col = 3'b000; ifb.req_valid = 1'b0; ifb.req_code = 3'b000;
    #1;
    cmp("rst_row", ifa.row, 4'b0000);
    cmp("rst_ready", ifa.req_ready, 1'b1);
    cmp("rst_busy", ifa.busy, 1'b0);
    cmp("rst_done", ifa.done, 1'b0);
    cmp("rst_err", ifa.err, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    step();

    // Key map table on instance A.
    for (int v = 0; v < 12; v++) begin
      wait_idle();
      ifa.req_valid = 1'b1; ifa.req_code = tbl[v].code; ifa.col = tbl[v].col;
      step();
      ifa.req_valid = 1'b0;
      #1;
      cmp($sformatf("tbl%0d_row", v), ifa.row, tbl[v].exp_row);
      cmp($sformatf("tbl%0d_err", v), ifa.err, tbl[v].exp_err);
    end

    // Test 1: rotating columns, key 100-coin.
    wait_idle();
    ifa.req_valid = 1'b1; ifa.req_code = KP_100; ifa.col = rot[0];
    for (int k = 1; k <= 13; k++) begin
      step();
      ifa.req_valid = 1'b0; ifa.col = rot[k % 3];
      #1;
      cmp("t1_row", ifa.row, (k <= 8 && (k % 3) == 0) ? 4'b0001 : 4'b0000);
      cmp("t1_done", ifa.done, k == 13);
    end
    cmp("t1_ready", ifa.req_ready, 1'b1);

    // Test 2: change key with matching and non-matching held column.
    for (int pass = 0; pass < 2; pass++) begin
      wait_idle();
      ifa.req_valid = 1'b1; ifa.req_code = KP_CHANGE;
      ifa.col = (pass == 0) ? 3'b100 : 3'b001;
      for (int k = 1; k <= 13; k++) begin
        step();
        ifa.req_valid = 1'b0;
        #1;
        cmp("t2_row", ifa.row, (pass == 0 && k <= 8) ? 4'b1000 : 4'b0000);
        cmp("t2_done", ifa.done, k == 13);
      end
    end

    // Test 3: bounce on instance B, key 500-coin, column 2 held.
    wait_idle();
    ifb.req_valid = 1'b1; ifb.req_code = KP_500; ifb.col = 3'b010;
    for (int k = 1; k <= 25; k++) begin
      step();
      ifb.req_valid = 1'b0;
      #1;
      cmp("t3_row", ifb.row, (k <= 24 && exp3[k-1]) ? 4'b0010 : 4'b0000);
      cmp("t3_done", ifb.done, k == 25);
    end

    // Test 4: illegal code in IDLE.
    wait_idle();
    ifa.req_valid = 1'b1; ifa.req_code = 3'b011; ifa.col = 3'b010;
    step();
    ifa.req_valid = 1'b0;
    #1;
    cmp("t4_err", ifa.err, 1'b1);
    cmp("t4_ready", ifa.req_ready, 1'b1);
    cmp("t4_busy", ifa.busy, 1'b0);
    cmp("t4_row", ifa.row, 4'b0000);
    step();
    cmp("t4_err_clear", ifa.err, 1'b0);

    // Test 5: asynchronous reset mid-press.
    wait_idle();
    ifa.req_valid = 1'b1; ifa.req_code = KP_RESET; ifa.col = 3'b010;
    step();
    ifa.req_valid = 1'b0;
    step(); step();
    #1;
    cmp("t5_row_before", ifa.row, 4'b1000);
    reset = 1'b1;
    model_reset();
    #1;
    cmp("t5_row", ifa.row, 4'b0000);
    cmp("t5_busy", ifa.busy, 1'b0);
    cmp("t5_ready", ifa.req_ready, 1'b1);
    step();
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      cmp("t5_no_done", ifa.done, 1'b0);
    end
    ifa.req_valid = 1'b1; ifa.req_code = KP_CANDY; ifa.col = 3'b001;
    step();
    ifa.req_valid = 1'b0;
    #1;
    cmp("t5_new_row", ifa.row, 4'b1000);

    // Test 6: back-to-back requests with req_valid held high.
    wait_idle();
    ifa.req_valid = 1'b1; ifa.req_code = KP_CANDY; ifa.col = 3'b001;
    step();
    ifa.req_code = KP_100;
    #1;
    cmp("t6_first_row", ifa.row, 4'b1000);
    for (int k = 2; k <= 13; k++) step();
    cmp("t6_done", ifa.done, 1'b1);
    cmp("t6_ready", ifa.req_ready, 1'b1);
    step();
    ifa.req_valid = 1'b0;
    cmp("t6_busy", ifa.busy, 1'b1);
    cmp("t6_second_row", ifa.row, 4'b0001);

    // Randomized traffic on both instances against the model.
    for (int n = 0; n < 1500; n++) begin
      ifa.req_valid = ($urandom_range(0, 3) == 0);
      ifa.req_code  = 3'($urandom_range(0, 7));
      ifa.col       = rand_col();
      ifb.req_valid = ($urandom_range(0, 3) == 0);
      ifb.req_code  = 3'($urandom_range(0, 7));
      ifb.col       = rand_col();
      step();
    end
    ifa.req_valid = 1'b0;
    ifb.req_valid = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
